// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared lcd_ctrl command codes, widths and writer state encoding
package lcd_pkg;

    localparam int DATA_WIDTH       = 8;
    localparam int COMM_WIDTH       = 3;
    localparam int FRAME_SIZE_WIDTH = 21;

    localparam logic [COMM_WIDTH-1:0] CMD_INITIAL     = 3'd1;
    localparam logic [COMM_WIDTH-1:0] CMD_CLEAR_RED   = 3'd2;
    localparam logic [COMM_WIDTH-1:0] CMD_CLEAR_GREEN = 3'd3;
    localparam logic [COMM_WIDTH-1:0] CMD_CLEAR_BLUE  = 3'd4;
    localparam logic [COMM_WIDTH-1:0] CMD_SHOW_IMAGE  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_FILL,
        ST_WAIT_ACK,
        ST_WAIT_END,
        ST_ERR
    } writer_state_e;

endpackage

// File: rtl/lcd_frame_writer_if.sv
// rtl/lcd_frame_writer_if.sv - pixel stream, FIFO write and lcd_ctrl command signals
interface lcd_frame_writer_if;
    import lcd_pkg::*;

    logic                  pix_valid;
    logic                  pix_ready;
    logic [15:0]           pix_data;
    logic                  pix_sof;
    logic                  fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_wr_data;
    logic                  fifo_full;
    logic [COMM_WIDTH-1:0] ctrl_command;
    logic                  ctrl_valid;
    logic                  ctrl_busy;
    logic                  ctrl_error;

    // Environment side: pixel source, FIFO and lcd_ctrl status
    modport master (
        output pix_valid, pix_data, pix_sof, fifo_full, ctrl_busy, ctrl_error,
        input  pix_ready, fifo_wr_en, fifo_wr_data, ctrl_command, ctrl_valid
    );

    // Writer side
    modport slave (
        input  pix_valid, pix_data, pix_sof, fifo_full, ctrl_busy, ctrl_error,
        output pix_ready, fifo_wr_en, fifo_wr_data, ctrl_command, ctrl_valid
    );

endinterface

// File: rtl/lcd_pixel_serializer.sv
// rtl/lcd_pixel_serializer.sv - one-pixel hold register split into high/low FIFO bytes; LCD_WRITER_BGR_SWAP_EN reorders to {B,G,R}
module lcd_pixel_serializer
    import lcd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  accept_en_i,
    input  logic                  need_sof_i,
    input  logic                  drop_i,
    input  logic                  pix_valid_i,
    input  logic [15:0]           pix_data_i,
    input  logic                  pix_sof_i,
    input  logic                  fifo_full_i,
    output logic                  pix_ready_o,
    output logic                  fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0] fifo_wr_data_o,
    output logic                  hold_full_o,
    output logic                  phase_lo_o
);

    logic [15:0] hold_q, hold_d;
    logic        full_q, full_d;
    logic        lo_q, lo_d;
    logic [15:0] pix_ordered;
    logic        load;

`ifdef LCD_WRITER_BGR_SWAP_EN
    assign pix_ordered = {pix_data_i[4:0], pix_data_i[10:5], pix_data_i[15:11]};
`else
    assign pix_ordered = pix_data_i;
`endif

    assign fifo_wr_en_o   = full_q && !fifo_full_i;
    assign pix_ready_o    = accept_en_i && (!full_q || (lo_q && !fifo_full_i));
    assign load           = pix_valid_i && pix_ready_o && (pix_sof_i || !need_sof_i);
    assign fifo_wr_data_o = lo_q ? hold_q[DATA_WIDTH-1:0] : hold_q[15:DATA_WIDTH];
    assign hold_full_o    = full_q;
    assign phase_lo_o     = lo_q;

    // Hold/phase update: drop wins, a new pixel replaces the drained one, else advance HI->LO->empty
    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        lo_d   = lo_q;
        if (drop_i) begin
            full_d = 1'b0;
            lo_d   = 1'b0;
        end else if (load) begin
            hold_d = pix_ordered;
            full_d = 1'b1;
            lo_d   = 1'b0;
        end else if (fifo_wr_en_o) begin
            if (lo_q) begin
                full_d = 1'b0;
                lo_d   = 1'b0;
            end else begin
                lo_d = 1'b1;
            end
        end
    end

    // Hold register and byte phase
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_q <= '0;
            full_q <= 1'b0;
            lo_q   <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
            lo_q   <= lo_d;
        end
    end

endmodule

// File: rtl/lcd_frame_writer.sv
// rtl/lcd_frame_writer.sv - frame FSM, byte counter and SHOW_IMAGE launch feeding lcd_ctrl's pixel FIFO (LCD_WRITER_BGR_SWAP_EN in serializer)
module lcd_frame_writer
    import lcd_pkg::*;
#(
    parameter int FRAME_PIXELS  = 76800,
    parameter int PREFILL_BYTES = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    lcd_frame_writer_if.slave  bus,
    output logic               frame_done,
    output logic               frame_error,
    output logic               writer_busy
);

    localparam int TOTAL_INT   = 2 * FRAME_PIXELS;
    localparam int PREFILL_INT = (PREFILL_BYTES < TOTAL_INT) ? PREFILL_BYTES : TOTAL_INT;
    localparam logic [FRAME_SIZE_WIDTH-1:0] TOTAL_BYTES = FRAME_SIZE_WIDTH'(TOTAL_INT);
    localparam logic [FRAME_SIZE_WIDTH-1:0] LAST_IDX    = FRAME_SIZE_WIDTH'(TOTAL_INT - 1);
    localparam logic [FRAME_SIZE_WIDTH-1:0] PREFILL_EFF = FRAME_SIZE_WIDTH'(PREFILL_INT);

    if (TOTAL_INT >= (1 << FRAME_SIZE_WIDTH)) begin : g_size_check
        $error("FRAME_SIZE_WIDTH cannot hold 2*FRAME_PIXELS");
    end

    writer_state_e               state_q, state_d;
    logic [FRAME_SIZE_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
    logic                        launched_q, launched_d;
    logic                        busy_seen_q, busy_seen_d;
    logic                        frame_done_q, frame_done_d;

    logic                        wr_en, hold_full, phase_lo, pix_ready;
    logic                        accept_en, need_sof, drop;
    logic [FRAME_SIZE_WIDTH-1:0] pending;
    logic                        all_taken, desync, last_byte, launch, err_hit;

    // Bytes still sitting in the hold register decide whether the last pixel is already in
    assign pending   = hold_full ? (phase_lo ? FRAME_SIZE_WIDTH'(1) : FRAME_SIZE_WIDTH'(2)) : '0;
    assign all_taken = (byte_cnt_q + pending) >= TOTAL_BYTES;
    assign accept_en = (state_q == ST_SYNC) || ((state_q == ST_FILL) && !all_taken);
    assign need_sof  = (state_q == ST_SYNC);
    assign desync    = (state_q == ST_FILL) && bus.pix_valid && pix_ready && bus.pix_sof;
    assign last_byte = (state_q == ST_FILL) && wr_en && (byte_cnt_q == LAST_IDX);
    assign launch    = !launched_q && (byte_cnt_q >= PREFILL_EFF)
                       && ((state_q == ST_FILL) || (state_q == ST_WAIT_ACK));
    assign err_hit   = bus.ctrl_error && launched_q;
    assign drop      = (state_d == ST_ERR) || (state_q == ST_IDLE) || (state_q == ST_ERR);

    assign bus.pix_ready    = pix_ready;
    assign bus.fifo_wr_en   = wr_en;
    assign bus.ctrl_valid   = launch;
    assign bus.ctrl_command = launch ? CMD_SHOW_IMAGE : '0;
    assign frame_done       = frame_done_q;
    assign frame_error      = (state_q == ST_ERR);
    assign writer_busy      = (state_q != ST_IDLE);

    lcd_pixel_serializer u_ser (
        .clk            (clk),
        .rstn           (rstn),
        .accept_en_i    (accept_en),
        .need_sof_i     (need_sof),
        .drop_i         (drop),
        .pix_valid_i    (bus.pix_valid),
        .pix_data_i     (bus.pix_data),
        .pix_sof_i      (bus.pix_sof),
        .fifo_full_i    (bus.fifo_full),
        .pix_ready_o    (pix_ready),
        .fifo_wr_en_o   (wr_en),
        .fifo_wr_data_o (bus.fifo_wr_data),
        .hold_full_o    (hold_full),
        .phase_lo_o     (phase_lo)
    );

    // Next state: controller error outranks desync, which outranks frame completion
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q + FRAME_SIZE_WIDTH'(wr_en);
        launched_d   = launched_q || launch;
        busy_seen_d  = busy_seen_q || (bus.ctrl_busy && (launched_q || launch));
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                byte_cnt_d  = '0;
                launched_d  = 1'b0;
                busy_seen_d = 1'b0;
                if (start && !bus.ctrl_busy) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (bus.pix_valid && pix_ready && bus.pix_sof) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (err_hit || desync) begin
                    state_d = ST_ERR;
                end else if (last_byte) begin
                    state_d = (busy_seen_q || (bus.ctrl_busy && launched_q)) ? ST_WAIT_END : ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (err_hit) state_d = ST_ERR;
                else if (bus.ctrl_busy && launched_q) state_d = ST_WAIT_END;
            end
            ST_WAIT_END: begin
                if (err_hit) begin
                    state_d = ST_ERR;
                end else if (!bus.ctrl_busy) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, byte counter, launch/busy flags and done pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= '0;
            launched_q   <= 1'b0;
            busy_seen_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            launched_q   <= launched_d;
            busy_seen_q  <= busy_seen_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// tb/tb_lcd_frame_writer.sv - scoreboard bench for lcd_frame_writer with a 4-pixel frame
module tb_lcd_frame_writer;
    import lcd_pkg::*;

    localparam int FP = 4;
    localparam int PB = 4;

    typedef struct {
        logic [15:0] pix;
        logic        sof;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic frame_done, frame_error, writer_busy;

    lcd_frame_writer_if bus();

    lcd_frame_writer #(.FRAME_PIXELS(FP), .PREFILL_BYTES(PB)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .bus         (bus),
        .frame_done  (frame_done),
        .frame_error (frame_error),
        .writer_busy (writer_busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [7:0] sb[$];
    int wr_count = 0;
    int launch_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    vec_t tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input logic [15:0] p);
`ifdef LCD_WRITER_BGR_SWAP_EN
        return {p[4:0], p[10:5], p[15:11]};
`else
        return p;
`endif
    endfunction

    // Monitor: pop expected bytes on every FIFO write, count launch/done/error pulses
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.ctrl_valid) begin
                launch_cnt++;
                check("launch_cmd", 32'(bus.ctrl_command), 32'd5);
                check("launch_after_bytes", wr_count, PB);
            end
            if (bus.fifo_wr_en) begin
                wr_count++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL fifo_write: got byte %0h, expected no write", bus.fifo_wr_data);
                end else begin
                    check("fifo_byte", 32'(bus.fifo_wr_data), 32'(sb.pop_front()));
                end
            end
            if (frame_done) done_cnt++;
            if (frame_error) err_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_pixel(input logic [15:0] d, input logic sof, input bit exp_en, input logic [15:0] ew);
        int n;
        n = 0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = d;
        bus.pix_sof   = sof;
        @(negedge clk);
        while (!bus.pix_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.pix_ready) begin
            check("pix_ready_timeout", 32'd0, 32'd1);
        end else if (exp_en) begin
            sb.push_back(ew[15:8]);
            sb.push_back(ew[7:0]);
        end
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check("drain_bytes", sb.size(), 0);
    endtask

    task automatic finish_frame();
        int n;
        int d0;
        d0 = done_cnt;
        n = 0;
        bus.ctrl_busy = 1'b1;
        repeat (3) tick();
        bus.ctrl_busy = 1'b0;
        while (done_cnt == d0 && n < 10) begin
            tick();
            n++;
        end
        tick();
        check("frame_done_count", done_cnt - d0, 1);
        check("idle_after_done", 32'(writer_busy), 32'd0);
    endtask

    task automatic run_table_frame();
        int l0;
        l0 = launch_cnt;
        wr_count = 0;
        pulse_start();
        check("busy_after_start", 32'(writer_busy), 32'd1);
        for (int i = 0; i < FP; i++) send_pixel(tbl[i].pix, tbl[i].sof, 1'b1, tbl[i].exp);
        drain();
        check("launch_once", launch_cnt - l0, 1);
        finish_frame();
    endtask

    initial begin
        int n;
        int e0;
        int d0;
        int l0;
        logic [15:0] w;

        tbl[0] = '{16'hF800, 1'b1, 16'hF800};
        tbl[1] = '{16'h07E0, 1'b0, 16'h07E0};
        tbl[2] = '{16'h001F, 1'b0, 16'h001F};
        tbl[3] = '{16'hFFFF, 1'b0, 16'hFFFF};
`ifdef LCD_WRITER_BGR_SWAP_EN
        tbl[0].exp = 16'h001F;
        tbl[2].exp = 16'hF800;
        w = 16'h001F;
`else
        w = 16'hF800;
`endif

        bus.pix_valid  = 1'b0;
        bus.pix_data   = '0;
        bus.pix_sof    = 1'b0;
        bus.fifo_full  = 1'b0;
        bus.ctrl_busy  = 1'b0;
        bus.ctrl_error = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bus.pix_ready, bus.fifo_wr_en, bus.fifo_wr_data, bus.ctrl_valid,
                                bus.ctrl_command, frame_done, frame_error, writer_busy}, 32'd0);
        rstn = 1'b1;
        tick();

        // Basic frame from the vector table
        run_table_frame();

        // Pixels before sof are discarded
        wr_count = 0;
        pulse_start();
        send_pixel(16'hAAAA, 1'b0, 1'b0, 16'h0);
        send_pixel(16'h5555, 1'b0, 1'b0, 16'h0);
        send_pixel(16'h1111, 1'b0, 1'b0, 16'h0);
        send_pixel(16'h1234, 1'b1, 1'b1, exp_word(16'h1234));
        send_pixel(16'hBEEF, 1'b0, 1'b1, exp_word(16'hBEEF));
        send_pixel(16'hCAFE, 1'b0, 1'b1, exp_word(16'hCAFE));
        send_pixel(16'h0F0F, 1'b0, 1'b1, exp_word(16'h0F0F));
        drain();
        finish_frame();

        // FIFO full stalls the pending low byte
        wr_count = 0;
        pulse_start();
        send_pixel(16'hABCD, 1'b1, 1'b1, exp_word(16'hABCD));
        tick();
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("full_no_write", 32'(bus.fifo_wr_en), 32'd0);
            check("full_not_ready", 32'(bus.pix_ready), 32'd0);
            tick();
        end
        bus.fifo_full = 1'b0;
        send_pixel(16'h1357, 1'b0, 1'b1, exp_word(16'h1357));
        send_pixel(16'h2468, 1'b0, 1'b1, exp_word(16'h2468));
        send_pixel(16'h9876, 1'b0, 1'b1, exp_word(16'h9876));
        drain();
        finish_frame();

        // Desync: sof on pixel 2
        e0 = err_cnt;
        d0 = done_cnt;
        pulse_start();
        send_pixel(16'h1111, 1'b1, 1'b1, exp_word(16'h1111));
        send_pixel(16'h2222, 1'b0, 1'b1, exp_word(16'h2222));
        send_pixel(16'h3333, 1'b1, 1'b0, 16'h0);
        check("desync_frame_error", 32'(frame_error), 32'd1);
        tick();
        check("desync_error_once", 32'(frame_error), 32'd0);
        check("desync_busy_drop", 32'(writer_busy), 32'd0);
        check("desync_bytes", sb.size(), 0);
        repeat (3) tick();
        check("desync_err_cnt", err_cnt - e0, 1);
        check("desync_no_done", done_cnt - d0, 0);

        // Controller error after launch
        e0 = err_cnt;
        l0 = launch_cnt;
        wr_count = 0;
        pulse_start();
        send_pixel(16'h4444, 1'b1, 1'b1, exp_word(16'h4444));
        send_pixel(16'h5555, 1'b0, 1'b1, exp_word(16'h5555));
        drain();
        n = 0;
        while (launch_cnt == l0 && n < 10) begin
            tick();
            n++;
        end
        check("ctrl_err_launch", launch_cnt - l0, 1);
        bus.ctrl_error = 1'b1;
        tick();
        bus.ctrl_error = 1'b0;
        check("ctrl_err_frame_error", 32'(frame_error), 32'd1);
        tick();
        check("ctrl_err_idle", 32'(writer_busy), 32'd0);
        check("ctrl_err_cnt", err_cnt - e0, 1);
        run_table_frame();

        // Start while controller busy is ignored
        bus.ctrl_busy = 1'b1;
        pulse_start();
        tick();
        check("start_ignored_busy", 32'(writer_busy), 32'd0);
        bus.ctrl_busy = 1'b0;
        tick();

        // Reset mid-FILL, with the colour-order check on pixel 0xF800
        wr_count = 0;
        pulse_start();
        send_pixel(16'hF800, 1'b1, 1'b1, w);
        tick();
        tick();
        check("f800_bytes_written", sb.size(), 0);
        rstn = 1'b0;
        #1;
        check("reset_midframe_outputs", {bus.pix_ready, bus.fifo_wr_en, bus.fifo_wr_data, bus.ctrl_valid,
                                         bus.ctrl_command, frame_done, frame_error, writer_busy}, 32'd0);
        sb.delete();
        tick();
        tick();
        rstn = 1'b1;
        tick();
        check("after_reset_idle", 32'(writer_busy), 32'd0);
        run_table_frame();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
